// File: rtl/prog_loader_pkg.sv
// Shared state, segment and mode definitions for the serial program loader.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, SEND, ACK, RUN, FIN, ERR} state_t;

  typedef enum logic {SEG_I = 1'b0, SEG_D = 1'b1} seg_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_IMEM = 2'b01;
  localparam logic [1:0] MODE_DMEM = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  function automatic logic [1:0] send_mode(input seg_t seg);
    return (seg == SEG_D) ? MODE_DMEM : MODE_IMEM;
  endfunction

endpackage

// File: rtl/prog_loader_frame_shifter.sv
// LSB-first frame serialiser: owns the sclk divider and the bit counter.
module frame_shifter
  import loader_pkg::*;
#(
  parameter int FRAME_W = 13,
  parameter int CLK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               sclk,
  output logic               mosi,
  output logic               done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] shreg;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               active;
  logic               tick;

  assign tick = active && (div_cnt == DIV_LAST);
  // done coincides with the edge that drops sclk after the last bit
  assign done = tick && sclk && (bit_cnt == BIT_LAST);
  assign mosi = shreg[0];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      active  <= 1'b0;
    end else if (load) begin
      shreg   <= frame;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            active <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: streams imem then dmem words to the target, one acked frame per word,
// then starts the target and waits for it to report completion.
module prog_loader
  import loader_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int CLK_DIV    = 1,
  parameter int ACK_TMO    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic              done_in,
  output logic              src_sel_out,
  output logic [ADDR_W-1:0] src_addr_out,
  input  logic [DATA_W-1:0] src_data_in,
  output logic              sclk_out,
  output logic              tgt_rst_n_out,
  output logic              mosi_out,
  output logic [1:0]        mode_out,
  output logic              busy_out,
  output logic              err_out
);

  localparam int FRAME_W = 1 + DATA_W + ADDR_W;
  localparam int TMO_W   = $clog2(ACK_TMO + 1);
  localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] D_LAST   = ADDR_W'((DMEM_DEPTH > 0) ? DMEM_DEPTH - 1 : 0);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TMO - 1);

  state_t             state;
  seg_t               seg;
  logic [ADDR_W-1:0]  word;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               done_q;
  logic               ack_edge;
  logic               abort;
  logic               last_word;
  logic               sh_load;
  logic               sh_done;
  logic [FRAME_W-1:0] frame;

  assign ack_edge     = done_in & ~done_q;
  assign abort        = ~start_in && (state != FIN) && (state != ERR);
  assign last_word    = (seg == SEG_I) ? (word == I_LAST) : (word == D_LAST);
  assign sh_load      = (state == FETCH);
  assign frame        = {1'b0, src_data_in, word};
  assign src_addr_out = word;
  assign src_sel_out  = (seg == SEG_D);

  frame_shifter #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .load  (sh_load),
    .frame (frame),
    .sclk  (sclk_out),
    .mosi  (mosi_out),
    .done  (sh_done)
  );

  always_ff @(posedge clk) begin
    tgt_rst_n_out <= rst_n;
  end

  // Outputs are set alongside each transition so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      seg      <= SEG_I;
      word     <= '0;
      tmo_cnt  <= '0;
      done_q   <= 1'b0;
      mode_out <= MODE_IDLE;
      busy_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      done_q <= done_in;
      if (abort) begin
        state    <= IDLE;
        seg      <= SEG_I;
        word     <= '0;
        mode_out <= MODE_IDLE;
        busy_out <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_in) begin
              state    <= FETCH;
              busy_out <= 1'b1;
            end
          end
          FETCH: begin
            state    <= SEND;
            mode_out <= send_mode(seg);
          end
          SEND: begin
            if (sh_done) begin
              state    <= ACK;
              mode_out <= MODE_IDLE;
              tmo_cnt  <= '0;
            end
          end
          ACK: begin
            if (ack_edge) begin
              if (!last_word) begin
                word  <= word + 1'b1;
                state <= FETCH;
              end else if (seg == SEG_I && DMEM_DEPTH > 0) begin
                seg   <= SEG_D;
                word  <= '0;
                state <= FETCH;
              end else begin
                state    <= RUN;
                mode_out <= MODE_RUN;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              state    <= ERR;
              err_out  <= 1'b1;
              busy_out <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          RUN: begin
            if (ack_edge) begin
              state    <= FIN;
              mode_out <= MODE_IDLE;
              busy_out <= 1'b0;
            end
          end
          FIN, ERR: begin
            if (!start_in) begin
              state   <= IDLE;
              seg     <= SEG_I;
              word    <= '0;
              err_out <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: three parameterisations, frames decoded off the wire
// and compared with a word-level model of the expected load sequence.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start, done, sel, sclk, tgt, mosi, busy, err;
  logic [3:0] addr  [3];
  logic [1:0] mode  [3];
  logic [7:0] sdata [3];
  logic [7:0] rom_i [16];
  logic [7:0] rom_d [16];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sdata[i] = sel[i] ? rom_d[addr[i]] : rom_i[addr[i]];
    end
  end

  prog_loader u_def (
    .clk(clk), .rst_n(rst_n), .start_in(start[0]), .done_in(done[0]),
    .src_sel_out(sel[0]), .src_addr_out(addr[0]), .src_data_in(sdata[0]),
    .sclk_out(sclk[0]), .tgt_rst_n_out(tgt[0]), .mosi_out(mosi[0]),
    .mode_out(mode[0]), .busy_out(busy[0]), .err_out(err[0]));

  prog_loader #(.IMEM_DEPTH(2), .DMEM_DEPTH(1), .CLK_DIV(3)) u_div (
    .clk(clk), .rst_n(rst_n), .start_in(start[1]), .done_in(done[1]),
    .src_sel_out(sel[1]), .src_addr_out(addr[1]), .src_data_in(sdata[1]),
    .sclk_out(sclk[1]), .tgt_rst_n_out(tgt[1]), .mosi_out(mosi[1]),
    .mode_out(mode[1]), .busy_out(busy[1]), .err_out(err[1]));

  prog_loader #(.IMEM_DEPTH(4), .DMEM_DEPTH(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start_in(start[2]), .done_in(done[2]),
    .src_sel_out(sel[2]), .src_addr_out(addr[2]), .src_data_in(sdata[2]),
    .sclk_out(sclk[2]), .tgt_rst_n_out(tgt[2]), .mosi_out(mosi[2]),
    .mode_out(mode[2]), .busy_out(busy[2]), .err_out(err[2]));

  function automatic int imem_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 2 : 4;
  endfunction

  function automatic int dmem_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 1 : 0;
  endfunction

  function automatic int cdiv_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  // Frame number idx of a full load: imem words first, then dmem words.
  function automatic logic [12:0] exp_frame(input int d, input int idx);
    int w;
    logic [7:0] v;
    if (idx < imem_of(d)) begin
      w = idx;
      v = rom_i[w];
    end else begin
      w = idx - imem_of(d);
      v = rom_d[w];
    end
    return {1'b0, v, w[3:0]};
  endfunction

  task automatic fill_roms;
    for (int i = 0; i < 16; i++) begin
      rom_i[i] = 8'($urandom);
      rom_d[i] = 8'($urandom);
    end
  endtask

  task automatic recv_check(input int d, input int idx);
    logic [12:0] f, want;
    logic [1:0]  m, want_m;
    int cyc, hi, nb, unst;
    bit ok;
    logic ps, pm;
    f = '0; m = 2'b00; cyc = 0; hi = 0; nb = 0; unst = 0; ok = 1'b0; ps = 1'b0; pm = 1'b0;
    want   = exp_frame(d, idx);
    want_m = (idx < imem_of(d)) ? 2'b01 : 2'b10;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (mode[d] != 2'b00) begin
        if (cyc == 0) m = mode[d];
        cyc++;
        if (sclk[d]) hi++;
        if (sclk[d] && !ps) begin
          if (mosi[d] !== pm) unst++;
          if (nb < 13) f[nb] = mosi[d];
          nb++;
        end
      end else if (cyc != 0) begin
        ok = 1'b1;
      end
      ps = sclk[d];
      pm = mosi[d];
    end
    n_total++; if (!ok) $display("[TB] FAIL send_end d%0d idx%0d: got no end of SEND, want one within 400 cycles", d, idx); else n_pass++;
    n_total++; if (f !== want) $display("[TB] FAIL frame d%0d idx%0d: got %h want %h", d, idx, f, want); else n_pass++;
    n_total++; if (m !== want_m) $display("[TB] FAIL send_mode d%0d idx%0d: got %b want %b", d, idx, m, want_m); else n_pass++;
    n_total++; if (nb !== 13) $display("[TB] FAIL bit_count d%0d idx%0d: got %0d want 13", d, idx, nb); else n_pass++;
    n_total++; if (cyc !== 26 * cdiv_of(d)) $display("[TB] FAIL send_len d%0d idx%0d: got %0d want %0d", d, idx, cyc, 26 * cdiv_of(d)); else n_pass++;
    n_total++; if (hi !== 13 * cdiv_of(d)) $display("[TB] FAIL sclk_high d%0d idx%0d: got %0d want %0d", d, idx, hi, 13 * cdiv_of(d)); else n_pass++;
    n_total++; if (unst !== 0) $display("[TB] FAIL mosi_stable d%0d idx%0d: got %0d changes at sclk rise want 0", d, idx, unst); else n_pass++;
  endtask

  task automatic send_ack(input int d);
    repeat (2) @(negedge clk);
    done[d] = 1'b1;
    @(negedge clk);
    done[d] = 1'b0;
  endtask

  task automatic wait_send(input int d);
    int t;
    t = 0;
    while (mode[d] == 2'b00 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_total++; if (mode[d] == 2'b00) $display("[TB] FAIL wait_send d%0d: got mode 00 want SEND within 400 cycles", d); else n_pass++;
  endtask

  task automatic run_frames(input int d, input int count);
    int nxt;
    logic [4:0] want_src;
    for (int idx = 0; idx < count; idx++) begin
      recv_check(d, idx);
      send_ack(d);
      if (idx < count - 1) begin
        nxt = idx + 1;
        want_src = (nxt < imem_of(d)) ? {1'b0, 4'(nxt)} : {1'b1, 4'(nxt - imem_of(d))};
        n_total++; if ({sel[d], addr[d]} !== want_src) $display("[TB] FAIL next_src d%0d idx%0d: got %h want %h", d, idx, {sel[d], addr[d]}, want_src); else n_pass++;
      end
    end
  endtask

  task automatic finish_run(input int d);
    n_total++; if (mode[d] !== 2'b11 || busy[d] !== 1'b1) $display("[TB] FAIL run_mode d%0d: got mode %b busy %b want 11/1", d, mode[d], busy[d]); else n_pass++;
    send_ack(d);
    n_total++; if ({mode[d], busy[d], err[d]} !== 4'b0000) $display("[TB] FAIL fin d%0d: got mode/busy/err %b want 0000", d, {mode[d], busy[d], err[d]}); else n_pass++;
    start[d] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_timeout(input int d);
    repeat (254) @(negedge clk);
    n_total++; if (err[d] !== 1'b0 || busy[d] !== 1'b1) $display("[TB] FAIL tmo_early d%0d: got err %b busy %b want 0/1", d, err[d], busy[d]); else n_pass++;
    @(negedge clk);
    n_total++; if ({err[d], busy[d], mode[d]} !== 4'b1000) $display("[TB] FAIL tmo_err d%0d: got err/busy/mode %b want 1000", d, {err[d], busy[d], mode[d]}); else n_pass++;
    start[d] = 1'b0;
    done[d]  = 1'b0;
    @(negedge clk);
    n_total++; if (err[d] !== 1'b0 || busy[d] !== 1'b0) $display("[TB] FAIL err_clear d%0d: got err %b busy %b want 0/0", d, err[d], busy[d]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = '0;
    done  = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++; if ({sclk[d], mosi[d], busy[d], err[d], tgt[d], sel[d], mode[d], addr[d]} !== 12'h000) $display("[TB] FAIL reset_outs d%0d: got %h want 000", d, {sclk[d], mosi[d], busy[d], err[d], tgt[d], sel[d], mode[d], addr[d]}); else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (tgt !== 3'b111) $display("[TB] FAIL tgt_release: got %b want 111", tgt); else n_pass++;
  endtask

  task automatic test_full_load;
    fill_roms();
    start[0] = 1'b1;
    run_frames(0, imem_of(0) + dmem_of(0));
    finish_run(0);
  endtask

  task automatic test_clk_div;
    fill_roms();
    start[1] = 1'b1;
    run_frames(1, imem_of(1) + dmem_of(1));
    finish_run(1);
  endtask

  task automatic test_no_dmem;
    fill_roms();
    start[2] = 1'b1;
    run_frames(2, imem_of(2) + dmem_of(2));
    finish_run(2);
  endtask

  task automatic test_ack_timeout;
    fill_roms();
    start[0] = 1'b1;
    run_frames(0, 5);
    recv_check(0, 5);
    expect_timeout(0);
  endtask

  task automatic test_stuck_done;
    fill_roms();
    done[0]  = 1'b1;
    start[0] = 1'b1;
    recv_check(0, 0);
    expect_timeout(0);
  endtask

  task automatic test_back_to_back;
    fill_roms();
    start[0] = 1'b1;
    run_frames(0, 7);
    wait_send(0);
    repeat (10) @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    n_total++; if ({sclk[0], mode[0], busy[0], sel[0], addr[0]} !== 9'h000) $display("[TB] FAIL abort d0: got %h want 000", {sclk[0], mode[0], busy[0], sel[0], addr[0]}); else n_pass++;
    start[0] = 1'b1;
    recv_check(0, 0);
    send_ack(0);
    wait_send(0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if ({sclk[0], mosi[0], mode[0], busy[0], tgt[0], addr[0]} !== 10'h000) $display("[TB] FAIL rst_mid d0: got %h want 000", {sclk[0], mosi[0], mode[0], busy[0], tgt[0], addr[0]}); else n_pass++;
    rst_n = 1'b1;
    recv_check(0, 0);
    n_total++; if (tgt[0] !== 1'b1) $display("[TB] FAIL tgt_after_rst: got %b want 1", tgt[0]); else n_pass++;
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_clk_div();
    test_no_dmem();
    test_ack_timeout();
    test_stuck_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
